onehot_encoder_16_4: RTL and testbench
======================================

ONEHOT_ENCODER_16_4 -- requirements
Module: onehot_encoder_16_4

Interface
REQ-001 SHALL provide parameter IN_ACTIVE_LOW, default 1, meaning 1 = input line asserted when 0 (NAND-predecoder polarity), 0 = asserted when 1.
REQ-002 SHALL provide port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL provide port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL provide port enc_in  input  16  line vector to encode, polarity per IN_ACTIVE_LOW.
REQ-005 SHALL provide port in_valid  input  1  enc_in is valid this cycle.
REQ-006 SHALL provide port in_ready  output  1  block accepts enc_in this cycle.
REQ-007 SHALL provide port enc_out  output  4  binary index of the asserted line.
REQ-008 SHALL provide port enc_err  output  1  encoding fault flag travelling with enc_out.
REQ-009 SHALL provide port out_valid  output  1  enc_out/enc_err hold a result.
REQ-010 SHALL provide port out_ready  input  1  consumer accepts the result this cycle.

Function
REQ-011 SHALL normalise input: asserted[i] = enc_in[i] XOR IN_ACTIVE_LOW.
REQ-012 SHALL implement a two-state FSM, EMPTY and FULL; out_valid = (state == FULL).
REQ-013 SHALL drive in_ready = (state == EMPTY) OR out_ready, combinationally.
REQ-014 SHALL define accept = in_valid AND in_ready, and load enc_out/enc_err on the clock edge of accept.
REQ-015 SHALL give a latency of exactly 1 cycle: a result accepted at edge N is visible with out_valid=1 after edge N.
REQ-016 SHALL set enc_out to the lowest index i with asserted[i]=1.
REQ-017 SHALL set enc_out=0 and enc_err=1 when no line is asserted (zero-hot).
REQ-018 SHALL transition EMPTY->FULL on accept, FULL->EMPTY on out_ready with no accept, and stay FULL on out_ready with accept (back-to-back, full throughput).
REQ-019 SHALL hold enc_out, enc_err and out_valid stable while FULL and out_ready=0, regardless of enc_in or in_valid.
REQ-020 SHALL ignore enc_in when in_valid=0; no internal state changes.
REQ-021 SHALL contain no combinational path from enc_in to enc_out or enc_err.

Reset
REQ-022 SHALL, on a clock edge with rst=1, set the state to EMPTY, out_valid=0, enc_out=4'h0 and enc_err=0.
REQ-023 SHALL drive in_ready=1 during reset.
REQ-024 SHALL discard a held result or a concurrent accept when rst asserts mid-operation; rst has priority over all other events.

Configuration
REQ-025 SHALL recognise macro ONEHOT_CHECK_EN.
REQ-026 SHALL, with ONEHOT_CHECK_EN defined, set enc_err=1 when the asserted-line count is not exactly 1 (zero-hot or multi-hot); enc_out still follows REQ-016/REQ-017.
REQ-027 SHALL, without ONEHOT_CHECK_EN, set enc_err=1 only for zero-hot; multi-hot silently yields the lowest index.

Verification
REQ-028 SHALL cover single line: IN_ACTIVE_LOW=1, enc_in=16'hFFF7, in_valid=1, out_ready=1 -> next cycle out_valid=1, enc_out=4'h3, enc_err=0.
REQ-029 SHALL cover exhaustive decode round-trip: drive each of the 16 active-low one-cold patterns produced by the 4-to-16 predecoder for codes 0..15 -> enc_out equals the code, enc_err=0.
REQ-030 SHALL cover multi-hot: enc_in=16'hFF5F (lines 5 and 7) -> enc_out=4'h5; enc_err=1 with ONEHOT_CHECK_EN, 0 without.
REQ-031 SHALL cover zero-hot: enc_in=16'hFFFF -> enc_out=4'h0, enc_err=1 in both builds.
REQ-032 SHALL cover backpressure: hold out_ready=0 for 3 cycles after loading code 9 while driving code 2 -> in_ready=0, enc_out stays 4'h9; raising out_ready then gives 4'h2 on the next cycle.
REQ-033 SHALL cover reset mid-operation: rst=1 for one cycle while FULL with code 0xA and in_valid=1 -> out_valid=0, enc_out=4'h0, enc_err=0 after the edge.

Source files
------------

// File: rtl/onehot_encoder_16_4.sv
// onehot_encoder_16_4: registered 16-to-4 one-hot (or one-cold) priority encoder with valid/ready handshake
//   clk       rising-edge clock for all state
//   rst       synchronous active-high reset
//   enc_in    16-bit line vector, asserted low when IN_ACTIVE_LOW=1, high otherwise
//   in_valid  enc_in is valid this cycle
//   in_ready  block accepts enc_in this cycle
//   enc_out   binary index of the lowest asserted line
//   enc_err   fault flag: zero-hot, plus multi-hot when ONEHOT_CHECK_EN is defined
//   out_valid enc_out/enc_err hold a result
//   out_ready consumer accepts the result this cycle
//   Macro ONEHOT_CHECK_EN enables multi-hot detection.
module onehot_encoder_16_4 #(
    parameter bit IN_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] enc_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [3:0]  enc_out,
    output logic        enc_err,
    output logic        out_valid,
    input  logic        out_ready
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t      state, state_nxt;
    logic [15:0] asserted;
    logic [3:0]  code_nxt;
    logic        err_nxt;
    logic        zero_hot;
    logic        accept;
    assign asserted = enc_in ^ {16{IN_ACTIVE_LOW}};
    assign zero_hot = ~|asserted;
    // Scanning from the top down lets the lowest asserted index win.
    always_comb begin
        code_nxt = 4'h0;
        for (int i = 15; i >= 0; i--)
            if (asserted[i]) code_nxt = 4'(i);
    end
`ifdef ONEHOT_CHECK_EN
    logic multi_hot;
    // Clearing the lowest set bit leaves something only when two or more lines are asserted.
    assign multi_hot = |(asserted & (asserted - 16'd1));
    assign err_nxt   = zero_hot | multi_hot;
`else
    assign err_nxt   = zero_hot;
`endif
    assign in_ready  = rst | (state == EMPTY) | out_ready;
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == FULL);
    always_comb begin
        state_nxt = state;
        if (state == EMPTY)
            state_nxt = accept ? FULL : EMPTY;
        else
            state_nxt = (out_ready && !accept) ? EMPTY : FULL;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= EMPTY;
            enc_out <= 4'h0;
            enc_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                enc_out <= code_nxt;
                enc_err <= err_nxt;
            end
        end
    end
endmodule

// File: tb/tb_onehot_encoder_16_4.sv
// tb_onehot_encoder_16_4: scoreboard bench for the registered one-hot encoder
module tb_onehot_encoder_16_4;
`ifdef ONEHOT_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] enc_in = 16'hFFFF;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid, enc_err;
    logic [3:0]  enc_out;
    logic [4:0]  exp_next = 5'h0;
    logic [4:0]  sb[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    onehot_encoder_16_4 #(.IN_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .enc_in(enc_in), .in_valid(in_valid), .in_ready(in_ready),
        .enc_out(enc_out), .enc_err(enc_err), .out_valid(out_valid), .out_ready(out_ready)
    );

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference result {err, code} for an active-low vector.
    function automatic logic [4:0] model(input logic [15:0] v);
        logic [15:0] a;
        logic [3:0]  c;
        int          n;
        a = ~v;
        c = 4'h0;
        n = 0;
        for (int i = 0; i < 16; i++)
            if (a[i]) begin
                if (n == 0) c = 4'(i);
                n++;
            end
        return {(n == 0) || (CHK && n > 1), c};
    endfunction

    // Scoreboard: push on accept, pop and compare on output handshake.
    always @(posedge clk) begin
        if (rst) sb.delete();
        else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check("sb_underflow", 16'(sb.size()), 16'd1);
                else check("result", {11'h0, enc_err, enc_out}, {11'h0, sb.pop_front()});
            end
            if (in_valid && in_ready) sb.push_back(exp_next);
        end
    end

    task automatic send(input logic [15:0] v, input logic [4:0] e);
        @(negedge clk);
        enc_in   = v;
        exp_next = e;
        in_valid = 1'b1;
        for (int k = 0; k < 20 && !in_ready; k++) @(negedge clk);
        check("accept_timeout", {15'h0, in_ready}, 16'h1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] v;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {15'h0, in_ready}, 16'h1);
        check("rst_out_valid", {15'h0, out_valid}, 16'h0);
        check("rst_enc_out", {12'h0, enc_out}, 16'h0);
        check("rst_enc_err", {15'h0, enc_err}, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        // Idle input is ignored
        enc_in = 16'hFFFE;
        repeat (2) @(negedge clk);
        check("idle_out_valid", {15'h0, out_valid}, 16'h0);
        // Single line with 1-cycle latency
        send(16'hFFF7, {1'b0, 4'h3});
        check("lat_out_valid", {15'h0, out_valid}, 16'h1);
        check("lat_enc_out", {12'h0, enc_out}, 16'h3);
        check("lat_enc_err", {15'h0, enc_err}, 16'h0);
        // Exhaustive decode round trip
        for (int c = 0; c < 16; c++) begin
            v = ~(16'h1 << c);
            send(v, {1'b0, 4'(c)});
        end
        // Multi-hot and zero-hot
        send(16'hFF5F, {CHK, 4'h5});
        send(16'hFFFF, {1'b1, 4'h0});
        // Random sparse patterns
        for (int n = 0; n < 24; n++) begin
            v = ~((16'h1 << $urandom_range(0, 15)) | ($urandom_range(0, 1) ? (16'h1 << $urandom_range(0, 15)) : 16'h0));
            if ($urandom_range(0, 5) == 0) v = 16'hFFFF;
            send(v, model(v));
        end
        repeat (3) @(negedge clk);
        check("drain", 16'(sb.size()), 16'd0);
        // Backpressure: hold 9 while 2 waits
        out_ready = 1'b0;
        send(~(16'h1 << 9), {1'b0, 4'h9});
        @(negedge clk);
        enc_in   = ~(16'h1 << 2);
        exp_next = {1'b0, 4'h2};
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("bp_in_ready", {15'h0, in_ready}, 16'h0);
            check("bp_enc_out", {12'h0, enc_out}, 16'h9);
            check("bp_out_valid", {15'h0, out_valid}, 16'h1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("bp_next", {12'h0, enc_out}, 16'h2);
        check("bp_next_valid", {15'h0, out_valid}, 16'h1);
        repeat (2) @(negedge clk);
        check("bp_drain", 16'(sb.size()), 16'd0);
        // Reset mid-operation while FULL with code A
        out_ready = 1'b0;
        send(~(16'h1 << 10), {1'b0, 4'hA});
        check("mid_full", {12'h0, enc_out}, 16'hA);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        enc_in   = ~(16'h1 << 3);
        #1 check("mid_in_ready", {15'h0, in_ready}, 16'h1);
        @(posedge clk);
        #1;
        check("mid_out_valid", {15'h0, out_valid}, 16'h0);
        check("mid_enc_out", {12'h0, enc_out}, 16'h0);
        check("mid_enc_err", {15'h0, enc_err}, 16'h0);
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_valid", {15'h0, out_valid}, 16'h0);
        send(16'hFFDF, {1'b0, 4'h5});
        repeat (3) @(negedge clk);
        check("final_drain", 16'(sb.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
